// File: rtl/branch_sequencer.sv
// rtl/branch_sequencer.sv - PC sequencer with conditional branches and a circular return-address stack
// Optional BRANCH_SEQ_STATS_EN adds saturating branch/taken statistics counters.
module branch_sequencer #(
  parameter int              XLEN      = 32,
  parameter int              RAS_DEPTH = 8,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter int              PC_STEP   = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic [XLEN-1:0] label,
  input  logic [3:0]      branch_op,
  input  logic [XLEN-1:0] result,
  input  logic            carry,
  input  logic            zero,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_next,
  output logic            taken,
  output logic            ras_empty,
  output logic            ras_full,
`ifdef BRANCH_SEQ_STATS_EN
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_taken,
`endif
  output logic            ras_err
);

  localparam int              PW   = $clog2(RAS_DEPTH);
  localparam int              CW   = $clog2(RAS_DEPTH + 1);
  localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_ras [RAS_DEPTH];
  logic [PW-1:0]   r_sp;
  logic [CW-1:0]   r_cnt;
  logic            r_empty;
  logic            r_full;
  logic            r_err;

  logic [XLEN-1:0] w_seq;
  logic [XLEN-1:0] w_top;
  logic [XLEN-1:0] w_next;
  logic            w_taken;
  logic            w_push;
  logic            w_pop;
  logic [CW-1:0]   w_cnt_next;

  always_comb begin
    w_seq   = r_pc + STEP;
    w_top   = r_ras[r_sp - PW'(1)];
    w_taken = 1'b0;
    case (branch_op)
      4'd1:    w_taken = 1'b1;
      4'd2:    w_taken = zero;
      4'd3:    w_taken = !zero;
      4'd4:    w_taken = carry;
      4'd5:    w_taken = !carry;
      4'd6:    w_taken = result[XLEN-1];
      4'd7:    w_taken = !result[XLEN-1];
      4'd8:    w_taken = 1'b1;
      4'd9:    w_taken = !r_empty;
      4'd10:   w_taken = 1'b1;
      default: w_taken = 1'b0;
    endcase
    if (!w_taken)
      w_next = w_seq;
    else if (branch_op == 4'd9)
      w_next = w_top;
    else if (branch_op == 4'd10)
      w_next = result;
    else
      w_next = label;
  end

  // A push at full depth overwrites the oldest slot, so occupancy saturates.
  always_comb begin
    w_push     = (branch_op == 4'd8);
    w_pop      = (branch_op == 4'd9) && !r_empty;
    w_cnt_next = r_cnt;
    if (w_push && r_cnt != CW'(RAS_DEPTH))
      w_cnt_next = r_cnt + CW'(1);
    else if (w_pop)
      w_cnt_next = r_cnt - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc    <= RESET_PC;
      r_sp    <= '0;
      r_cnt   <= '0;
      r_empty <= 1'b1;
      r_full  <= 1'b0;
      r_err   <= 1'b0;
    end else if (!stall) begin
      r_pc    <= w_next;
      r_cnt   <= w_cnt_next;
      r_empty <= (w_cnt_next == '0);
      r_full  <= (w_cnt_next == CW'(RAS_DEPTH));
      if (w_push)
        r_sp <= r_sp + PW'(1);
      else if (w_pop)
        r_sp <= r_sp - PW'(1);
      if (branch_op == 4'd9 && r_empty)
        r_err <= 1'b1;
    end
  end

  // Entry data is left untouched by reset; occupancy alone defines validity.
  always_ff @(posedge clk) begin
    if (!reset && !stall && w_push)
      r_ras[r_sp] <= w_seq;
  end

`ifdef BRANCH_SEQ_STATS_EN
  logic [31:0] r_stat_br;
  logic [31:0] r_stat_tk;
  logic        w_is_br;

  always_comb begin
    w_is_br = (branch_op >= 4'd1) && (branch_op <= 4'd10);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stat_br <= '0;
      r_stat_tk <= '0;
    end else if (!stall && w_is_br) begin
      if (r_stat_br != '1)
        r_stat_br <= r_stat_br + 32'd1;
      if (w_taken && r_stat_tk != '1)
        r_stat_tk <= r_stat_tk + 32'd1;
    end
  end

  assign stat_branches = r_stat_br;
  assign stat_taken    = r_stat_tk;
`endif

  assign pc        = r_pc;
  assign pc_next   = w_next;
  assign taken     = w_taken;
  assign ras_empty = r_empty;
  assign ras_full  = r_full;
  assign ras_err   = r_err;

endmodule

// File: tb/tb_branch_sequencer.sv
// tb/tb_branch_sequencer.sv - directed vector bench for branch_sequencer
module tb_branch_sequencer;

  logic        clk = 1'b0;
  logic        reset, stall, carry, zero;
  logic [31:0] label, result;
  logic [3:0]  branch_op;
  logic [31:0] pc, pc_next;
  logic        taken, ras_empty, ras_full, ras_err;
`ifdef BRANCH_SEQ_STATS_EN
  logic [31:0] stat_branches, stat_taken;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  branch_sequencer dut (
    .clk(clk), .reset(reset), .stall(stall), .label(label), .branch_op(branch_op),
    .result(result), .carry(carry), .zero(zero), .pc(pc), .pc_next(pc_next),
    .taken(taken), .ras_empty(ras_empty), .ras_full(ras_full),
`ifdef BRANCH_SEQ_STATS_EN
    .stat_branches(stat_branches), .stat_taken(stat_taken),
`endif
    .ras_err(ras_err)
  );

  typedef struct packed {
    logic        rst;
    logic        stl;
    logic [3:0]  op;
    logic [31:0] lbl;
    logic [31:0] res;
    logic        cy;
    logic        zr;
    logic [31:0] exp_next;
    logic        exp_taken;
    logic [31:0] exp_pc;
    logic        exp_empty;
    logic        exp_full;
    logic        exp_err;
  } vec_t;

  vec_t vecs [19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic s, input logic [3:0] op,
                       input logic [31:0] l, input logic [31:0] res,
                       input logic cy, input logic zr);
    reset = r; stall = s; branch_op = op; label = l; result = res; carry = cy; zero = zr;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = '{0,0, 4'd0,  32'h0,   32'h0,        0,0, 32'h4,   1'b0, 32'h4,   1,0,0};
    vecs[1]  = '{0,0, 4'd0,  32'h0,   32'h0,        0,0, 32'h8,   1'b0, 32'h8,   1,0,0};
    vecs[2]  = '{0,0, 4'd0,  32'h0,   32'h0,        0,0, 32'hC,   1'b0, 32'hC,   1,0,0};
    vecs[3]  = '{0,0, 4'd1,  32'h20,  32'h0,        0,0, 32'h20,  1'b1, 32'h20,  1,0,0};
    vecs[4]  = '{0,1, 4'd2,  32'h10,  32'h0,        0,1, 32'h10,  1'b1, 32'h20,  1,0,0};
    vecs[5]  = '{0,0, 4'd2,  32'h10,  32'h0,        0,0, 32'h24,  1'b0, 32'h24,  1,0,0};
    vecs[6]  = '{0,0, 4'd2,  32'h10,  32'h0,        0,1, 32'h10,  1'b1, 32'h10,  1,0,0};
    vecs[7]  = '{0,0, 4'd3,  32'h40,  32'h0,        0,0, 32'h40,  1'b1, 32'h40,  1,0,0};
    vecs[8]  = '{0,0, 4'd4,  32'h80,  32'h0,        0,0, 32'h44,  1'b0, 32'h44,  1,0,0};
    vecs[9]  = '{0,0, 4'd5,  32'h80,  32'h0,        0,0, 32'h80,  1'b1, 32'h80,  1,0,0};
    vecs[10] = '{0,0, 4'd6,  32'h100, 32'h80000000, 0,0, 32'h100, 1'b1, 32'h100, 1,0,0};
    vecs[11] = '{0,0, 4'd7,  32'h180, 32'h80000000, 0,0, 32'h104, 1'b0, 32'h104, 1,0,0};
    vecs[12] = '{0,0, 4'd10, 32'h0,   32'h200,      0,0, 32'h200, 1'b1, 32'h200, 1,0,0};
    vecs[13] = '{0,0, 4'd12, 32'h300, 32'h0,        1,1, 32'h204, 1'b0, 32'h204, 1,0,0};
    vecs[14] = '{0,0, 4'd9,  32'h300, 32'h0,        0,0, 32'h208, 1'b0, 32'h208, 1,0,1};
    vecs[15] = '{1,1, 4'd1,  32'h40,  32'h0,        0,0, 32'h40,  1'b1, 32'h0,   1,0,0};
    vecs[16] = '{0,0, 4'd1,  32'h40,  32'h0,        0,0, 32'h40,  1'b1, 32'h40,  1,0,0};
    vecs[17] = '{0,0, 4'd8,  32'h100, 32'h0,        0,0, 32'h100, 1'b1, 32'h100, 0,0,0};
    vecs[18] = '{0,0, 4'd9,  32'h0,   32'h0,        0,0, 32'h44,  1'b1, 32'h44,  1,0,0};

    drive(1, 0, 4'd0, 32'h0, 32'h0, 0, 0);
    tick();
    chk("reset pc", pc, 32'h0);
    chk("reset empty", {31'b0, ras_empty}, 32'h1);
    chk("reset full", {31'b0, ras_full}, 32'h0);
    chk("reset err", {31'b0, ras_err}, 32'h0);

    for (int i = 0; i < 19; i++) begin
      drive(vecs[i].rst, vecs[i].stl, vecs[i].op, vecs[i].lbl, vecs[i].res, vecs[i].cy, vecs[i].zr);
      chk($sformatf("vec%0d pc_next", i), pc_next, vecs[i].exp_next);
      chk($sformatf("vec%0d taken", i), {31'b0, taken}, {31'b0, vecs[i].exp_taken});
      tick();
      chk($sformatf("vec%0d pc", i), pc, vecs[i].exp_pc);
      chk($sformatf("vec%0d empty", i), {31'b0, ras_empty}, {31'b0, vecs[i].exp_empty});
      chk($sformatf("vec%0d full", i), {31'b0, ras_full}, {31'b0, vecs[i].exp_full});
      chk($sformatf("vec%0d err", i), {31'b0, ras_err}, {31'b0, vecs[i].exp_err});
    end

    // Overflow: 9 calls into an 8-deep stack, then drain and underflow.
    drive(1, 0, 4'd0, 32'h0, 32'h0, 0, 0);
    tick();
    for (int i = 0; i < 9; i++) begin
      drive(0, 0, 4'd8, 32'((i + 1) * 4), 32'h0, 0, 0);
      tick();
      chk($sformatf("call%0d pc", i), pc, 32'((i + 1) * 4));
      chk($sformatf("call%0d full", i), {31'b0, ras_full}, (i >= 7) ? 32'h1 : 32'h0);
    end
    chk("ovf err", {31'b0, ras_err}, 32'h0);
    for (int k = 0; k < 8; k++) begin
      drive(0, 0, 4'd9, 32'h0, 32'h0, 0, 0);
      chk($sformatf("ret%0d taken", k), {31'b0, taken}, 32'h1);
      chk($sformatf("ret%0d pc_next", k), pc_next, 32'(36 - 4 * k));
      tick();
      chk($sformatf("ret%0d pc", k), pc, 32'(36 - 4 * k));
    end
    chk("drain empty", {31'b0, ras_empty}, 32'h1);
    drive(0, 0, 4'd9, 32'h0, 32'h0, 0, 0);
    chk("uflow taken", {31'b0, taken}, 32'h0);
    chk("uflow pc_next", pc_next, 32'hC);
    tick();
    chk("uflow pc", pc, 32'hC);
    chk("uflow err", {31'b0, ras_err}, 32'h1);

    // Reset in the middle of nested calls drops stacked returns.
    drive(1, 0, 4'd0, 32'h0, 32'h0, 0, 0);
    tick();
    drive(0, 0, 4'd8, 32'h50, 32'h0, 0, 0);
    tick();
    drive(0, 0, 4'd8, 32'h60, 32'h0, 0, 0);
    tick();
    drive(1, 0, 4'd0, 32'h0, 32'h0, 0, 0);
    tick();
    drive(0, 0, 4'd9, 32'h0, 32'h0, 0, 0);
    chk("midrst taken", {31'b0, taken}, 32'h0);
    chk("midrst pc_next", pc_next, 32'h4);
    tick();
    chk("midrst empty", {31'b0, ras_empty}, 32'h1);
    chk("midrst err", {31'b0, ras_err}, 32'h1);

    // Stall holds pc and RAS while pc_next tracks the inputs.
    drive(1, 0, 4'd0, 32'h0, 32'h0, 0, 0);
    tick();
    for (int k = 0; k < 2; k++) begin
      drive(0, 1, 4'd1, 32'h80, 32'h0, 0, 0);
      chk($sformatf("stall%0d pc_next", k), pc_next, 32'h80);
      tick();
      chk($sformatf("stall%0d pc", k), pc, 32'h0);
    end
    drive(0, 1, 4'd8, 32'h90, 32'h0, 0, 0);
    tick();
    chk("stall call empty", {31'b0, ras_empty}, 32'h1);
    chk("stall call pc", pc, 32'h0);
    drive(0, 0, 4'd1, 32'h80, 32'h0, 0, 0);
    tick();
    chk("unstall pc", pc, 32'h80);

`ifdef BRANCH_SEQ_STATS_EN
    drive(1, 0, 4'd0, 32'h0, 32'h0, 0, 0);
    tick();
    chk("stat reset br", stat_branches, 32'h0);
    drive(0, 0, 4'd1, 32'h40, 32'h0, 0, 0);  tick();
    drive(0, 0, 4'd2, 32'h80, 32'h0, 0, 0);  tick();
    drive(0, 0, 4'd2, 32'h80, 32'h0, 0, 1);  tick();
    drive(0, 0, 4'd0, 32'h0,  32'h0, 0, 0);  tick();
    drive(0, 0, 4'd10, 32'h0, 32'h10, 0, 0); tick();
    chk("stat branches", stat_branches, 32'd4);
    chk("stat taken", stat_taken, 32'd3);
    chk("stat pc", pc, 32'h10);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
